// File: rtl/dmem_responder_if.sv
// Request/response channel between a load/store unit and a data-memory responder.
// The master modport drives requests and accepts responses; the slave modport does the reverse.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Stallable data-memory target: accepts one request, waits WAIT_CYCLES, performs a
// byte-enabled word access on a local array and holds the response until it is taken.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam bit          NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CW-1:0] CNT_INIT = NO_WAIT ? CW'(0) : CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic            access;
  logic            acc_we;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_be;
  logic            acc_err;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     rsp_rdata_d;

  // With no wait states the access happens on the accept edge, straight from the bus.
  assign accept    = (state_q == IDLE) && bus.req_valid && !reset;
  assign access    = NO_WAIT ? accept : ((state_q == BUSY) && (cnt_q == '0));
  assign acc_we    = NO_WAIT ? bus.req_we    : we_q;
  assign acc_addr  = NO_WAIT ? bus.req_addr  : addr_q;
  assign acc_wdata = NO_WAIT ? bus.req_wdata : wdata_q;
  assign acc_be    = NO_WAIT ? bus.req_be    : be_q;

  assign acc_err     = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
  assign acc_idx     = acc_addr[AW+1:2];
  assign rsp_rdata_d = (acc_we || acc_err) ? 32'h0 : mem[acc_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (access) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= acc_err;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            cnt_q   <= CNT_INIT;
            state_q <= NO_WAIT ? RESP : BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is deliberately unreset so committed stores survive a reset.
  always_ff @(posedge clk) begin
    if (access && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for access, error, stall
// and reset cases, and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmem_responder;

  localparam int unsigned WAIT2 = 2;
  localparam int unsigned TMO   = 50;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  dmem_responder_if b2 ();
  dmem_responder_if b0 ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAIT2)) u_w2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request to the 2-wait instance and return just after its accept edge.
  task automatic send2(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    int guard;
    b2.req_valid = 1'b1;
    b2.req_we    = we;
    b2.req_addr  = addr;
    b2.req_wdata = wdata;
    b2.req_be    = be;
    b2.rsp_ready = 1'b0;
    guard = 0;
    while (!b2.req_ready && guard < int'(TMO)) begin
      step();
      guard++;
    end
    check_eq("accept_wait", 32'(guard < int'(TMO)), 32'd1);
    step();
    b2.req_valid = 1'b0;
    b2.req_we    = ~we;
    b2.req_addr  = 32'hFFFF_FFFF;
    b2.req_wdata = 32'h5555_5555;
    b2.req_be    = 4'hF;
  endtask

  task automatic wait_rsp2(output int lat);
    lat = 0;
    while (!b2.rsp_valid && lat < int'(TMO)) begin
      step();
      lat++;
    end
  endtask

  task automatic txn2(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int stall,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    send2(we, addr, wdata, be);
    wait_rsp2(lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(WAIT2));
    check_eq({tag, "_rdata"}, b2.rsp_rdata, exp_rdata);
    check_eq({tag, "_err"}, 32'(b2.rsp_err), 32'(exp_err));
    for (int s = 0; s < stall; s++) begin
      step();
      check_eq({tag, "_hold_valid"}, 32'(b2.rsp_valid), 32'd1);
      check_eq({tag, "_hold_rdata"}, b2.rsp_rdata, exp_rdata);
      check_eq({tag, "_hold_err"}, 32'(b2.rsp_err), 32'(exp_err));
      check_eq({tag, "_hold_rdy"}, 32'(b2.req_ready), 32'd0);
    end
    b2.rsp_ready = 1'b1;
    step();
    b2.rsp_ready = 1'b0;
    check_eq({tag, "_rdy_after"}, 32'(b2.req_ready), 32'd1);
    check_eq({tag, "_valid_after"}, 32'(b2.rsp_valid), 32'd0);
  endtask

  logic [31:0] b2b_data [2];
  int          lat_r;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    b2b_data[0] = 32'h0BAD_F00D;
    b2b_data[1] = 32'h600D_CAFE;

    // Reset with a request pending on the bus: it must not be taken.
    reset        = 1'b1;
    b2.req_valid = 1'b1;
    b2.req_we    = 1'b1;
    b2.req_addr  = 32'h0000_0010;
    b2.req_wdata = 32'h1111_1111;
    b2.req_be    = 4'hF;
    b2.rsp_ready = 1'b0;
    b0.req_valid = 1'b0;
    b0.req_we    = 1'b0;
    b0.req_addr  = 32'h0;
    b0.req_wdata = 32'h0;
    b0.req_be    = 4'h0;
    b0.rsp_ready = 1'b0;
    step();
    step();
    check_eq("rst_req_ready", 32'(b2.req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(b2.rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", b2.rsp_rdata, 32'h0);
    check_eq("rst_rsp_err", 32'(b2.rsp_err), 32'd0);
    b2.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(b2.req_ready), 32'd1);
    step();
    check_eq("post_rst_no_rsp", 32'(b2.rsp_valid), 32'd0);

    // Basic store/load, byte-enable merge, errors and boundaries.
    txn2("st_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0);
    txn2("ld_full", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0);
    txn2("st_byte0", 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, 32'h0, 1'b0);
    txn2("ld_merge", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEAD_BEAA, 1'b0);
    txn2("ld_misal", 1'b0, 32'h13, 32'h0, 4'h0, 0, 32'h0, 1'b1);
    txn2("ld_oor", 1'b0, 32'h400, 32'h0, 4'h0, 0, 32'h0, 1'b1);
    txn2("st_oor", 1'b1, 32'h410, 32'h1111_1111, 4'hF, 0, 32'h0, 1'b1);
    txn2("st_misal", 1'b1, 32'h12, 32'h2222_2222, 4'hF, 0, 32'h0, 1'b1);
    txn2("st_be0", 1'b1, 32'h10, 32'h3333_3333, 4'h0, 0, 32'h0, 1'b0);
    txn2("ld_intact", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEAD_BEAA, 1'b0);
    txn2("st_top", 1'b1, 32'h3FC, 32'h5A5A_A5A5, 4'b1010, 0, 32'h0, 1'b0);
    txn2("st_top2", 1'b1, 32'h3FC, 32'h0102_0304, 4'b0101, 0, 32'h0, 1'b0);
    txn2("ld_top", 1'b0, 32'h3FC, 32'h0, 4'h0, 0, 32'h5A02_A504, 1'b0);

    // Response held while the requester stalls.
    txn2("ld_stall", 1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDEAD_BEAA, 1'b0);

    // Reset during BUSY discards the pending store.
    txn2("st_prior", 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1'b0);
    txn2("ld_prior", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0);
    send2(1'b1, 32'h20, 32'h1234_5678, 4'hF);
    reset = 1'b1;
    #1;
    check_eq("busy_rst_ready", 32'(b2.req_ready), 32'd0);
    check_eq("busy_rst_valid", 32'(b2.rsp_valid), 32'd0);
    check_eq("busy_rst_rdata", b2.rsp_rdata, 32'h0);
    check_eq("busy_rst_err", 32'(b2.rsp_err), 32'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    txn2("ld_after_busy_rst", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0);

    // Reset during RESP drops the response but keeps the completed store.
    send2(1'b1, 32'h24, 32'h0000_0077, 4'hF);
    wait_rsp2(lat_r);
    check_eq("resp_rst_lat", 32'(lat_r), 32'(WAIT2));
    reset = 1'b1;
    #1;
    check_eq("resp_rst_valid", 32'(b2.rsp_valid), 32'd0);
    step();
    reset = 1'b0;
    #1;
    txn2("ld_after_resp_rst", 1'b0, 32'h24, 32'h0, 4'h0, 0, 32'h0000_0077, 1'b0);

    // Zero-wait instance: back-to-back stores then loads, one accept every two cycles.
    b0.rsp_ready = 1'b1;
    b0.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b0.req_we    = (i < 2);
      b0.req_addr  = 32'(4 * (i % 2));
      b0.req_wdata = (i < 2) ? b2b_data[i % 2] : 32'hFFFF_FFFF;
      b0.req_be    = 4'hF;
      check_eq("b2b_ready", 32'(b0.req_ready), 32'd1);
      step();
      check_eq("b2b_valid", 32'(b0.rsp_valid), 32'd1);
      check_eq("b2b_busy", 32'(b0.req_ready), 32'd0);
      check_eq("b2b_err", 32'(b0.rsp_err), 32'd0);
      check_eq("b2b_rdata", b0.rsp_rdata, (i < 2) ? 32'h0 : b2b_data[i % 2]);
      if (i == 3) b0.req_valid = 1'b0;
      step();
      check_eq("b2b_done", 32'(b0.rsp_valid), 32'd0);
    end
    step();
    check_eq("b2b_no_extra", 32'(b0.rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory load/store port. It accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states. It performs a byte-enabled word access on an internal array, then returns read data and an error flag over a second valid/ready handshake. It sits between the datapath's load/store unit and the data storage, and it replaces zero-latency memory with a realistic, stallable target.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the array (power of two, 16..4096)
- WAIT_CYCLES, 2: wait states between accept and memory access (0..15)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables for stores (bit i selects bits [8i+7:8i])
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  32  load data (0 for stores and for errors)
- rsp_err  out  1  misaligned or out-of-range access

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready (accept edge e0), register we/addr/wdata/be.
  - If WAIT_CYCLES=0, perform the access at e0 and go to RESP.
  - Otherwise go to BUSY with wait counter = WAIT_CYCLES-1.
- BUSY:
  - req_ready=0.
  - The counter decrements each edge.
  - At the edge where the counter is 0, perform the access and go to RESP.
- RESP:
  - req_ready=0 and rsp_valid=1.
  - rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready, then go to IDLE at that edge.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2].
- Error when req_addr[1:0]≠0 or req_addr ≥ 4·DEPTH_WORDS:
  - No write occurs.
  - rsp_rdata=0, rsp_err=1.
- Store: only bytes with req_be=1 are written. be=4'b0000 is a legal no-op store that still responds with err=0. rsp_rdata=0.
- Load: rsp_rdata = full word as of the access edge. A store completed earlier is visible to a later load.
- The array is not reset. Contents are undefined until written. Committed writes survive reset.
- Inputs on the request channel are ignored outside the accept edge.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=0 while reset is high, and 1 in the first cycle after release.
- Latency: rsp_valid rises in the cycle after edge e0+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles after acceptance.
- Back-to-back throughput: with rsp_ready held high, one transaction per WAIT_CYCLES+2 cycles. A new accept is possible in the cycle after the response handshake edge.
- No overlap: req_ready and rsp_valid are never both 1.
- Response stall: rsp_ready low holds RESP indefinitely with outputs unchanged.
- Reset mid-operation:
  - A reset asserted in BUSY before the access edge discards the pending store; the array is unchanged.
  - A reset asserted in RESP drops the response; a store performed at its access edge remains.
- req_valid asserted during reset is not accepted.

## Test plan
- Store 0xDEADBEEF, be=4'hF, addr 0x10, WAIT_CYCLES=2, then load 0x10 -> each rsp_valid appears 3 cycles after accept; load returns 0xDEADBEEF, err=0.
- Store 0x000000AA with be=4'b0001 to 0x10 after the above, then load -> 0xDEADBEAA.
- Load addr 0x13 (misaligned) and load addr 0x400 with DEPTH_WORDS=256 -> rsp_err=1, rsp_rdata=0 for both; a following load of 0x10 is unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata, rsp_err stable, req_ready=0. Then raise rsp_ready -> req_ready=1 next cycle.
- WAIT_CYCLES=0, back-to-back stores to 0x0 then 0x4 with rsp_ready=1 -> one accept every 2 cycles; rsp_valid one cycle after each accept.
- Store 0x12345678 to 0x20, assert reset during BUSY -> all outputs 0 immediately. After release, a load of 0x20 returns its prior contents (not 0x12345678).
